pio_button_in: RTL and testbench
================================

PIO_BUTTON_IN -- requirements
Module: pio_button_in

Interface
REQ-001 Parameter WIDTH, default 8: number of input pins, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter DEBOUNCE, default 0: consecutive-cycle stability count; 0 = bypass, 1..65535 allowed.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external pins (buttons/switches).
REQ-012 readdata  output  32  registered read data, zero-extended above WIDTH.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Register map: 0 = DATA (RO, debounced pin value); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (RW, WIDTH bits); 3 = EDGECAP (R, write-1-to-clear per bit).
REQ-015 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-016 DEBOUNCE = 0: stable value = sync2 directly.
REQ-017 DEBOUNCE = D > 0: per-bit counter; reset to 0 when sync2 == stable; increment when different; when different and count == D-1, stable <= sync2 and count <= 0.
REQ-018 stable_d SHALL register stable every cycle; edge = rising (stable & ~stable_d), falling (~stable & stable_d) or any (stable ^ stable_d) per EDGE_TYPE.
REQ-019 Latency: in_port change set up before edge N, held -> EDGECAP bit set at edge N+2+D.
REQ-020 EDGECAP bit set by edge; cleared by write (chipselect & ~write_n & address == 3) with writedata bit = 1; set and clear in same cycle -> bit stays set.
REQ-021 Writes to address 0 or 1 SHALL have no effect; writes to address 2 load IRQMASK <= writedata[WIDTH-1:0] at that edge.
REQ-022 irq SHALL be combinational OR-reduction of (EDGECAP & IRQMASK); no extra latency.
REQ-023 Read: readdata updates at the edge after chipselect & write_n (read latency 1) with selected register; otherwise holds previous value.
REQ-024 Reads SHALL have no side effects (EDGECAP not cleared by read).
REQ-025 Pulses shorter than D consecutive cycles at sync2 SHALL not change stable nor set EDGECAP.

Reset
REQ-026 On reset: sync1, sync2, stable, stable_d, counters, IRQMASK, EDGECAP, readdata = 0; irq = 0 from next cycle.
REQ-027 stable_d and stable SHALL both be 0 after reset so a pin held high at reset release SHALL produce a rising edge once synchronized (documented behaviour).
REQ-028 Reset mid-debounce or with EDGECAP set SHALL discard all pending state in one cycle.

Verification
REQ-029 D=0, EDGE_TYPE=0, IRQMASK=0x01: in_port 0x00->0x01 before edge N -> EDGECAP=0x01 at N+2, irq=1; write 0x01 to addr 3 -> irq=0 next cycle.
REQ-030 D=4: in_port bit0 high for 3 cycles then low -> DATA stays 0x00, EDGECAP 0x00; held 6 cycles -> DATA=0x01 at N+5, EDGECAP=0x01 at N+6.
REQ-031 EDGE_TYPE=2: in_port 0x00->0x80->0x00 (spaced) -> EDGECAP bit7 set on each; mask 0x00 -> irq stays 0, EDGECAP still reads 0x80.
REQ-032 Edge on bit3 in same cycle as write 0x08 to addr 3 -> EDGECAP bit3 remains 1.
REQ-033 Write 0xA5 to addr 2, read addr 2 -> readdata=0x000000A5 one cycle after; read addr 1 -> 0x00000000.
REQ-034 reset asserted while EDGECAP=0xFF, IRQMASK=0xFF -> next edge all registers 0, irq=0.

Source files
------------

// File: rtl/pio_button_in_if.sv
// Avalon-MM slave bus for the button/switch PIO: word address, select,
// active-low write strobe, write data and registered read data.
interface pio_button_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_button_in.sv
// Button/switch input PIO: synchronizer, optional per-bit debounce, edge capture
// with write-1-to-clear, interrupt mask and a level interrupt output.
module pio_button_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  pio_button_in_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & bus.write_n;

  // Bits of writedata above WIDTH carry no meaning for any register.
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign stable = sync2_q;
    end else begin : g_debounce
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic             bit_stable_q;
        logic             bit_stable_d;

        // The counter restarts whenever the input agrees with the accepted
        // value, so only an unbroken run of DEBOUNCE differing cycles flips it.
        always_comb begin
          count_d      = '0;
          bit_stable_d = bit_stable_q;
          if (sync2_q[gi] != bit_stable_q) begin
            if (count_q == CNT_W'(DEBOUNCE - 1)) begin
              bit_stable_d = sync2_q[gi];
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            count_q      <= '0;
            bit_stable_q <= 1'b0;
          end else begin
            count_q      <= count_d;
            bit_stable_q <= bit_stable_d;
          end
        end

        assign stable[gi] = bit_stable_q;
      end
    end
  endgenerate

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = stable & ~stable_prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~stable & stable_prev_q;
    end else begin : g_any
      assign edge_det = stable ^ stable_prev_q;
    end
  endgenerate

  // A new edge wins over a simultaneous clear so no event is ever lost.
  always_comb begin
    clear_mask = '0;
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      clear_mask = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clear_mask) | edge_det;

    irqmask_d = irqmask_q;
    if (wr_en && (bus.address == ADDR_MASK)) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (bus.address)
        ADDR_DATA:    readdata_d = 32'(stable);
        ADDR_MASK:    readdata_d = 32'(irqmask_q);
        ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev_q <= '0;
      edgecap_q     <= '0;
      irqmask_q     <= '0;
      readdata_q    <= '0;
    end else begin
      stable_prev_q <= stable;
      edgecap_q     <= edgecap_d;
      irqmask_q     <= irqmask_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_button_in.sv
// Scoreboard bench for pio_button_in: three instances (plain rising, debounced,
// any-edge); reads queue their expected readdata/irq, a monitor checks them.
module tb_pio_button_in;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  in_a, in_b, in_c;
  logic [2:0]  cs, wn, rd_pend;
  logic [1:0]  addr [3];
  logic [31:0] wd [3];
  logic [31:0] rdata [3];
  logic        irq_a, irq_b, irq_c;
  logic [2:0]  irq_w;
  logic        done;
  logic        reported;

  pio_button_in_if bus_a ();
  pio_button_in_if bus_b ();
  pio_button_in_if bus_c ();

  assign bus_a.address = addr[0];
  assign bus_a.chipselect = cs[0];
  assign bus_a.write_n = wn[0];
  assign bus_a.writedata = wd[0];
  assign bus_b.address = addr[1];
  assign bus_b.chipselect = cs[1];
  assign bus_b.write_n = wn[1];
  assign bus_b.writedata = wd[1];
  assign bus_c.address = addr[2];
  assign bus_c.chipselect = cs[2];
  assign bus_c.write_n = wn[2];
  assign bus_c.writedata = wd[2];
  assign rdata[0] = bus_a.readdata;
  assign rdata[1] = bus_b.readdata;
  assign rdata[2] = bus_c.readdata;
  assign irq_w = {irq_c, irq_b, irq_a};

  pio_button_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_a), .irq(irq_a)
  );
  pio_button_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .in_port(in_b), .irq(irq_b)
  );
  pio_button_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave), .in_port(in_c), .irq(irq_c)
  );

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  m_exp;
  string m_name;
  int    checks = 0;
  int    errors = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input int k, input logic [1:0] a, input logic [31:0] d,
                    input logic i, input string nm);
    exp_t e;
    e.dut  = 2'(k);
    e.data = d;
    e.irq  = i;
    exp_q.push_back(e);
    name_q.push_back(nm);
    addr[k] = a;
    wn[k] = 1'b1;
    cs[k] = 1'b1;
    @(posedge clk);
    #1;
    cs[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
    addr[k] = a;
    wd[k] = d;
    wn[k] = 1'b0;
    cs[k] = 1'b1;
    @(posedge clk);
    #1;
    cs[k] = 1'b0;
    wn[k] = 1'b1;
  endtask

  always @(posedge clk) rd_pend <= cs & wn;

  // Readdata answers the strobe one edge later; irq is sampled alongside it.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_pend[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: dut%0d readdata=0x%08h, required no read pending", k, rdata[k]);
        end else begin
          m_exp = exp_q.pop_front();
          m_name = name_q.pop_front();
          if (m_exp.dut != 2'(k) || rdata[k] !== m_exp.data || irq_w[k] !== m_exp.irq) begin
            errors++;
            $display("FAIL %s: dut%0d readdata=0x%08h irq=%b, required dut%0d readdata=0x%08h irq=%b",
                     m_name, k, rdata[k], irq_w[k], m_exp.dut, m_exp.data, m_exp.irq);
          end else begin
            $display("read %s: dut%0d readdata=0x%08h irq=%b ok", m_name, k, rdata[k], irq_w[k]);
          end
        end
      end
    end
    if (done && !reported) begin
      reported = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required summary before it");
    $fatal(1, "watchdog");
  end

  initial begin
    done = 1'b0;
    reported = 1'b0;
    reset = 1'b1;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    cs = '0;
    wn = '1;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0;
      wd[k] = '0;
    end
    idle(3);
    reset = 1'b0;

    // Reset state
    rd(0, 2'd0, 32'h0, 1'b0, "a_rst_data");
    rd(0, 2'd1, 32'h0, 1'b0, "a_rst_rsvd");
    rd(0, 2'd2, 32'h0, 1'b0, "a_rst_mask");
    rd(0, 2'd3, 32'h0, 1'b0, "a_rst_edgecap");
    rd(1, 2'd3, 32'h0, 1'b0, "b_rst_edgecap");
    rd(2, 2'd3, 32'h0, 1'b0, "c_rst_edgecap");

    // Mask register, reserved word, ignored writes
    wr(0, 2'd2, 32'hFFFF_FFA5);
    rd(0, 2'd2, 32'h0000_00A5, 1'b0, "a_mask_rw");
    rd(0, 2'd1, 32'h0, 1'b0, "a_rsvd_read");
    wr(0, 2'd0, 32'hFF);
    wr(0, 2'd1, 32'hFF);
    rd(0, 2'd2, 32'h0000_00A5, 1'b0, "a_mask_after_ro_wr");
    rd(0, 2'd0, 32'h0, 1'b0, "a_data_after_ro_wr");
    rd(0, 2'd1, 32'h0, 1'b0, "a_rsvd_after_wr");
    wr(0, 2'd2, 32'h01);

    // Rising edge lands in EDGECAP two edges after the pin change
    in_a = 8'h01;
    rd(0, 2'd3, 32'h0, 1'b0, "a_edge_n0");
    rd(0, 2'd3, 32'h0, 1'b0, "a_edge_n1");
    rd(0, 2'd3, 32'h0, 1'b1, "a_edge_n2");
    rd(0, 2'd3, 32'h01, 1'b1, "a_edge_n3");
    rd(0, 2'd0, 32'h01, 1'b1, "a_data_high");
    rd(0, 2'd3, 32'h01, 1'b1, "a_read_no_clear");
    wr(0, 2'd3, 32'h01);
    rd(0, 2'd3, 32'h0, 1'b0, "a_w1c_clear");

    // Edge on bit3 coinciding with its clear
    in_a = 8'h09;
    idle(2);
    wr(0, 2'd3, 32'h08);
    rd(0, 2'd3, 32'h08, 1'b0, "a_set_beats_clear");
    wr(0, 2'd3, 32'h08);
    rd(0, 2'd3, 32'h0, 1'b0, "a_clear_bit3");

    // Debounce: 3-cycle glitch rejected
    in_b = 8'h01;
    idle(3);
    in_b = 8'h00;
    idle(8);
    rd(1, 2'd0, 32'h0, 1'b0, "b_glitch_data");
    rd(1, 2'd3, 32'h0, 1'b0, "b_glitch_edgecap");

    // Debounce: held input, DATA changes at N+5
    in_b = 8'h01;
    for (int i = 0; i < 7; i++) rd(1, 2'd0, (i == 6) ? 32'h01 : 32'h0, 1'b0, "b_data_timing");
    wr(1, 2'd3, 32'h01);
    in_b = 8'h00;
    idle(8);
    rd(1, 2'd3, 32'h0, 1'b0, "b_fall_not_captured");

    // Debounce: held input, EDGECAP set at N+6
    in_b = 8'h01;
    for (int i = 0; i < 8; i++) rd(1, 2'd3, (i == 7) ? 32'h01 : 32'h0, 1'b0, "b_edgecap_timing");

    // Any-edge mode with mask 0: both directions captured, irq stays low
    in_c = 8'h80;
    for (int i = 0; i < 4; i++) rd(2, 2'd3, (i == 3) ? 32'h80 : 32'h0, 1'b0, "c_rise");
    wr(2, 2'd3, 32'h80);
    in_c = 8'h00;
    for (int i = 0; i < 4; i++) rd(2, 2'd3, (i == 3) ? 32'h80 : 32'h0, 1'b0, "c_fall");
    rd(2, 2'd0, 32'h0, 1'b0, "c_data_low");

    // Reset with everything set
    wr(0, 2'd2, 32'hFF);
    in_a = 8'h00;
    idle(4);
    in_a = 8'hFF;
    idle(3);
    rd(0, 2'd3, 32'hFF, 1'b1, "a_all_edges");
    rd(0, 2'd2, 32'hFF, 1'b1, "a_all_mask");
    reset = 1'b1;
    in_a = 8'h04;
    rd(0, 2'd3, 32'h0, 1'b0, "a_reset_clears");
    reset = 1'b0;
    rd(0, 2'd2, 32'h0, 1'b0, "a_mask_after_reset");
    rd(0, 2'd3, 32'h0, 1'b0, "a_release_n1");
    rd(0, 2'd3, 32'h0, 1'b0, "a_release_n2");
    rd(0, 2'd3, 32'h04, 1'b0, "a_release_edge");

    idle(2);
    done = 1'b1;
  end

endmodule
